// File: rtl/alu_pkg.sv
// alu_pkg: shared decode constants, FSM states and flag bit positions for alu_muldiv
package alu_pkg;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] F_MFHI   = 6'b010000;
   localparam logic [5:0] F_MTHI   = 6'b010001;
   localparam logic [5:0] F_MFLO   = 6'b010010;
   localparam logic [5:0] F_MTLO   = 6'b010011;
   localparam logic [5:0] F_MULT   = 6'b011000;
   localparam logic [5:0] F_MULTU  = 6'b011001;
   localparam logic [5:0] F_DIV    = 6'b011010;
   localparam logic [5:0] F_DIVU   = 6'b011011;
   localparam int FLAG_Z  = 2;
   localparam int FLAG_N  = 1;
   localparam int FLAG_DZ = 0;
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one-bit-per-cycle shift-add multiplier / restoring divider on unsigned magnitudes
module muldiv_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             div_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] r,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] d, diff;
   logic [WIDTH:0] sum, sh;
   logic ge;
   // add-or-skip for multiply, trial subtract of the shifted remainder for divide
   always_comb begin
      sum  = {1'b0, r} + (q[0] ? {1'b0, d} : '0);
      sh   = {r, q[WIDTH-1]};
      ge   = sh >= {1'b0, d};
      diff = sh[WIDTH-1:0] - d;
   end
   // r:q is the partial product (mul) or remainder:quotient shifting dividend (div)
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r <= '0;
         q <= '0;
         d <= '0;
      end else if (load) begin
         r <= '0;
         q <= a;
         d <= b;
      end else if (step) begin
         if (div_mode) begin
            r <= ge ? diff : sh[WIDTH-1:0];
            q <= {q[WIDTH-2:0], ge};
         end else
            {r, q} <= {sum, q[WIDTH-1:1]};
      end
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: MIPS HI/LO multiply/divide unit with mfhi/mflo/mthi/mtlo
module alu_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      instruction,
   input  logic [WIDTH-1:0] regA,
   input  logic [WIDTH-1:0] regB,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [2:0]       flags
);
   localparam int CW = $clog2(WIDTH);
   state_t st, nxt;
   logic [CW-1:0] cnt;
   logic [5:0] funct;
   logic rtype, is_mul, is_div, sgn, a_neg, b_neg, load, step, idle_go;
   logic neg_q, neg_r, div_op, unused_bits;
   logic [WIDTH-1:0] a_mag, b_mag, it_r, it_q, fix_hi, fix_lo;
   logic [2*WIDTH-1:0] prod;
   logic [2:0] fix_flags;

   assign funct       = instruction[5:0];
   assign rtype       = instruction[31:26] == OP_RTYPE;
   assign unused_bits = ^instruction[25:6];
   assign is_mul      = rtype && (funct == F_MULT || funct == F_MULTU);
   assign is_div      = rtype && (funct == F_DIV || funct == F_DIVU);
   assign sgn         = funct == F_MULT || funct == F_DIV;
   assign a_neg       = sgn && regA[WIDTH-1];
   assign b_neg       = sgn && regB[WIDTH-1];
   assign a_mag       = a_neg ? -regA : regA;
   assign b_mag       = b_neg ? -regB : regB;
   assign idle_go     = st == S_IDLE && start;
   assign step        = st == S_MUL || st == S_DIV;
   assign busy        = st != S_IDLE;
   assign result      = rtype && funct == F_MFHI ? hi : rtype && funct == F_MFLO ? lo : '0;

   muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk(clk), .reset(reset), .load(load), .step(step), .div_mode(div_op),
      .a(a_mag), .b(b_mag), .r(it_r), .q(it_q)
   );

   // state register
   always_ff @(posedge clk or posedge reset)
      if (reset) st <= S_IDLE;
      else st <= nxt;

   // next state; a zero divisor never leaves IDLE
   always_comb begin
      nxt  = st;
      load = 1'b0;
      case (st)
         S_IDLE: if (start && (is_mul || (is_div && regB != '0))) begin
            load = 1'b1;
            nxt  = is_mul ? S_MUL : S_DIV;
         end
         S_MUL, S_DIV: if (cnt == CW'(WIDTH-1)) nxt = S_FIX;
         default: nxt = S_IDLE;
      endcase
   end

   // sign fix-up of the magnitude result and the flags it produces
   always_comb begin
      prod      = neg_q ? -{it_r, it_q} : {it_r, it_q};
      fix_hi    = div_op ? (neg_r ? -it_r : it_r) : prod[2*WIDTH-1:WIDTH];
      fix_lo    = div_op ? (neg_q ? -it_q : it_q) : prod[WIDTH-1:0];
      fix_flags = '0;
      fix_flags[FLAG_Z] = {fix_hi, fix_lo} == '0;
      fix_flags[FLAG_N] = div_op ? fix_lo[WIDTH-1] : fix_hi[WIDTH-1];
   end

   // HI/LO, flags, done pulse, iteration count and latched operation attributes
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         hi     <= '0;
         lo     <= '0;
         flags  <= '0;
         done   <= 1'b0;
         cnt    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         div_op <= 1'b0;
      end else begin
         done <= 1'b0;
         cnt  <= load ? '0 : step ? cnt + CW'(1) : cnt;
         if (load) begin
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            div_op <= is_div;
         end
         if (idle_go && rtype && funct == F_MTHI) hi <= regA;
         if (idle_go && rtype && funct == F_MTLO) lo <= regA;
         if (idle_go && is_div && regB == '0) begin
            done  <= 1'b1;
            flags <= 3'b001 << FLAG_DZ;
         end
         if (st == S_FIX) begin
            hi    <= fix_hi;
            lo    <= fix_lo;
            flags <= fix_flags;
            done  <= 1'b1;
         end
      end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: scoreboard bench for the HI/LO multiply/divide unit
module tb_alu_muldiv;
   import alu_pkg::*;
   localparam int W = 32;
   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic [2:0]  flags;
      int          lat;
   } exp_t;

   logic clk = 0, reset = 1, start = 0, busy, done;
   logic [31:0] instruction = '0;
   logic [W-1:0] regA = '0, regB = '0, result, hi, lo;
   logic [2:0] flags;
   exp_t sb[$];
   int n_chk = 0, n_pass = 0;
   logic [31:0] m_hi = '0, m_lo = '0;

   alu_muldiv #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .instruction(instruction), .regA(regA), .regB(regB),
      .start(start), .busy(busy), .done(done), .result(result), .hi(hi), .lo(lo), .flags(flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic exp_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic [63:0] p;
      e.lat = 34;
      e.flags = '0;
      if (f == F_MULT || f == F_MULTU) begin
         p = (f == F_MULT) ? longint'($signed(a)) * longint'($signed(b)) : {32'd0, a} * {32'd0, b};
         {e.hi, e.lo} = p;
         e.flags[1] = e.hi[31];
      end else if (b == 0) begin
         e.hi = m_hi;
         e.lo = m_lo;
         e.flags = 3'b001;
         e.lat = 1;
         return e;
      end else begin
         if (f == F_DIVU) begin
            e.lo = a / b;
            e.hi = a % b;
         end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            e.lo = 32'h80000000;
            e.hi = 0;
         end else begin
            e.lo = $signed(a) / $signed(b);
            e.hi = $signed(a) % $signed(b);
         end
         e.flags[1] = e.lo[31];
      end
      e.flags[2] = {e.hi, e.lo} == 64'd0;
      return e;
   endfunction

   // caller is at a negedge; returns at a negedge one cycle after done
   task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input exp_t e);
      int n;
      exp_t g;
      sb.push_back(e);
      instruction = {26'd0, f};
      regA = a;
      regB = b;
      start = 1;
      @(negedge clk);
      start = 0;
      regA = $urandom;
      regB = $urandom;
      n = 1;
      if (e.lat > 1) check({tag, " busy"}, busy, 1);
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, " latency"}, n, e.lat);
      check({tag, " busy at done"}, busy, 0);
      g = sb.pop_front();
      check({tag, " hi"}, hi, g.hi);
      check({tag, " lo"}, lo, g.lo);
      check({tag, " flags"}, flags, g.flags);
      m_hi = g.hi;
      m_lo = g.lo;
      @(negedge clk);
      check({tag, " done width"}, done, 0);
   endtask

   initial begin
      int n;
      logic saw;
      logic [5:0] fs[4];
      logic [5:0] f;
      logic [31:0] a, b;
      fs = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
      repeat (2) @(negedge clk);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset hi", hi, 0);
      check("reset lo", lo, 0);
      check("reset flags", flags, 0);
      reset = 0;
      run_op("mult 3*-2", F_MULT, 3, 32'hFFFFFFFE, '{32'hFFFFFFFF, 32'hFFFFFFFA, 3'b010, 34});
      run_op("multu max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, '{32'hFFFFFFFE, 32'h00000001, 3'b010, 34});
      run_op("div -7/2", F_DIV, 32'hFFFFFFF9, 2, '{32'hFFFFFFFF, 32'hFFFFFFFD, 3'b010, 34});
      run_op("divu 7/0", F_DIVU, 7, 0, '{32'hFFFFFFFF, 32'hFFFFFFFD, 3'b001, 1});
      run_op("div min/-1", F_DIV, 32'h80000000, 32'hFFFFFFFF, '{32'h0, 32'h80000000, 3'b010, 34});
      run_op("divu 0/5", F_DIVU, 0, 5, '{32'h0, 32'h0, 3'b100, 34});
      run_op("div 7/-2", F_DIV, 7, 32'hFFFFFFFE, '{32'h1, 32'hFFFFFFFD, 3'b010, 34});
      // mthi/mtlo then reads
      instruction = {26'd0, F_MTHI};
      regA = 32'h1234;
      start = 1;
      @(negedge clk);
      start = 0;
      check("mthi busy", busy, 0);
      check("mthi done", done, 0);
      instruction = {26'd0, F_MFHI};
      #1 check("mfhi result", result, 32'h1234);
      @(negedge clk);
      instruction = {26'd0, F_MTLO};
      regA = 32'h5678;
      start = 1;
      @(negedge clk);
      start = 0;
      instruction = {26'd0, F_MFLO};
      #1 check("mflo result", result, 32'h5678);
      instruction = {26'd0, F_MULT};
      #1 check("result other", result, 0);
      m_hi = 32'h1234;
      m_lo = 32'h5678;
      // non-R-type and unknown funct are ignored
      @(negedge clk);
      instruction = {6'b000001, 20'd0, F_MULT};
      regA = 9;
      regB = 9;
      start = 1;
      @(negedge clk);
      instruction = {26'd0, 6'b100000};
      check("bad opcode busy", busy, 0);
      @(negedge clk);
      start = 0;
      check("bad funct busy", busy, 0);
      check("bad funct done", done, 0);
      check("ignored hi", hi, 32'h1234);
      // second start and mthi while busy are ignored; result shows old HI
      instruction = {26'd0, F_MULT};
      regA = 5;
      regB = 7;
      start = 1;
      @(negedge clk);
      start = 0;
      n = 1;
      repeat (4) @(negedge clk);
      n += 4;
      regA = 9;
      regB = 9;
      start = 1;
      @(negedge clk);
      n++;
      instruction = {26'd0, F_MTHI};
      regA = 32'hDEAD;
      @(negedge clk);
      n++;
      start = 0;
      instruction = {26'd0, F_MFHI};
      #1 check("busy mfhi", result, 32'h1234);
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("busy restart latency", n, 34);
      check("busy restart hi", hi, 0);
      check("busy restart lo", lo, 35);
      check("busy restart flags", flags, 3'b000);
      @(negedge clk);
      // reset mid-divide aborts without done
      instruction = {26'd0, F_DIV};
      regA = 100;
      regB = 3;
      start = 1;
      @(negedge clk);
      start = 0;
      repeat (9) @(negedge clk);
      reset = 1;
      #1;
      check("abort busy", busy, 0);
      check("abort hi", hi, 0);
      check("abort lo", lo, 0);
      check("abort flags", flags, 0);
      @(negedge clk);
      reset = 0;
      saw = 0;
      repeat (40) begin
         @(negedge clk);
         saw |= done;
      end
      check("abort no done", saw, 0);
      m_hi = 0;
      m_lo = 0;
      run_op("mult after reset", F_MULT, 32'hFFFFFFFB, 32'hFFFFFFF9, '{32'h0, 32'd35, 3'b000, 34});
      // random operations against the arithmetic model
      for (int i = 0; i < 10; i++) begin
         f = fs[$urandom_range(0, 3)];
         a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         b = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
         run_op("random", f, a, b, model(f, a, b));
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width (even, >=8).
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port instruction  input  32  MIPS R-type word; opcode [31:26], funct [5:0].
REQ-005 SHALL have port regA  input  WIDTH  rs operand (multiplicand/dividend, mthi/mtlo source).
REQ-006 SHALL have port regB  input  WIDTH  rt operand (multiplier/divisor).
REQ-007 SHALL have port start  input  1  instruction/operands valid this cycle.
REQ-008 SHALL have port busy  output  1  iterative operation in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse: operation complete, hi/lo updated.
REQ-010 SHALL have port result  output  WIDTH  mfhi/mflo read data, combinational.
REQ-011 SHALL have port hi, lo  output  WIDTH each  current HI/LO registers.
REQ-012 SHALL have port flags  output  3  [2] zero, [1] negative, [0] divide-by-zero.

Function
REQ-013 SHALL decode only opcode 000000 with funct mfhi 010000, mthi 010001, mflo 010010, mtlo 010011, mult 011000, multu 011001, div 011010, divu 011011; all others SHALL be ignored (no state change, no done).
REQ-014 SHALL accept start only in IDLE; start while busy SHALL be ignored.
REQ-015 SHALL use FSM IDLE -> MUL or DIV (accept edge) -> FIX (after WIDTH iteration edges) -> IDLE (FIX edge writes HI/LO, asserts done).
REQ-016 SHALL assert busy from the cycle after accept until the FIX edge; done SHALL be high exactly one cycle, WIDTH+2 cycles after accept edge, with busy low.
REQ-017 mult/multu SHALL produce the full 2*WIDTH product, HI = upper, LO = lower; signed via magnitude iteration plus FIX negation.
REQ-018 div/divu SHALL use restoring division, one quotient bit per edge; LO = quotient truncated toward zero, HI = remainder with dividend's sign.
REQ-019 signed MIN / -1 SHALL yield LO = MIN, HI = 0, flags[0] = 0.
REQ-020 divisor zero SHALL skip iteration: done pulses the cycle after accept, HI/LO unchanged, flags[0] = 1.
REQ-021 flags SHALL update only with done: [2] = ({HI,LO} == 0), [1] = HI MSB for mult*, LO MSB for div*.
REQ-022 mthi/mtlo with start in IDLE SHALL write regA at that edge, no busy, no done; while busy SHALL be ignored.
REQ-023 result SHALL show HI for mfhi, LO for mflo, else 0; during busy it SHALL show pre-operation HI/LO.
REQ-024 operands SHALL be latched at accept; regA/regB changes during busy SHALL have no effect.

Reset
REQ-025 reset SHALL immediately force IDLE, busy = 0, done = 0, hi = lo = 0, flags = 000, aborting any operation with no done.
REQ-026 first accept SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-027 opcode/funct constants, FSM state enum and flag bit indices SHALL live in shared package alu_pkg.
REQ-028 shift-add/restoring-subtract datapath SHALL be one sub-module muldiv_iter; FSM, HI/LO and flags in alu_muldiv.

Verification (WIDTH = 32)
REQ-029 mult regA=3, regB=-2 -> hi=FFFFFFFF, lo=FFFFFFFA, flags=010, done 34 cycles after accept.
REQ-030 multu FFFFFFFF x FFFFFFFF -> hi=FFFFFFFE, lo=00000001, flags=010.
REQ-031 div -7 / 2 -> lo=FFFFFFFD, hi=FFFFFFFF; divu 7 / 0 -> done next cycle, hi/lo unchanged, flags=001.
REQ-032 div 80000000 / FFFFFFFF -> lo=80000000, hi=0; divu 0 / 5 -> hi=lo=0, flags=100.
REQ-033 mthi 1234 then mfhi -> result=00001234; mult started, second start at cycle 5 -> ignored, first result intact.
REQ-034 reset asserted at cycle 10 of a div -> busy=0, hi=lo=0, no done pulse; next mult completes normally.
